xc_malu_mul_iter: RTL and testbench

XC_MALU_MUL_ITER -- requirements
Module: xc_malu_mul_iter

---
 rtl/xc_malu_mul_iter_if.sv | 13 +
 rtl/xc_malu_mul_iter.sv | 78 +++++++
 tb/tb_xc_malu_mul_iter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/xc_malu_mul_iter_if.sv
// xc_malu_mul_iter_if: request/response handshake bundle for the iterative multiplier
interface xc_malu_mul_iter_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  modport master (output in_valid, op, rs1, rs2, out_ready, input in_ready, out_valid, result);
  modport slave  (input in_valid, op, rs1, rs2, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/xc_malu_mul_iter.sv
// xc_malu_mul_iter: constant-time shift-add multiplier, BPC rs2 bits per cycle; carry-less ops need XC_MALU_MUL_ITER_CLMUL_EN
module xc_malu_mul_iter #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              flush,
  xc_malu_mul_iter_if.slave bus
);
  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_n;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   rs1_r, rs2_r;
  logic              accept, last, hi_sel, rsv;
  // one radix-2 step: add (or subtract for signed rs2 MSB) into the XLEN+1-bit top, then shift right
  function automatic logic [2*XLEN-1:0] step(input logic [2*XLEN-1:0] a, input logic [XLEN-1:0] m,
                                             input logic [2:0] o, input logic b, input logic sub);
    logic          s;
    logic [XLEN:0] hi, pp, sm;
    s  = o == 3'b001 || o == 3'b010;
    hi = {s & a[2*XLEN-1], a[2*XLEN-1:XLEN]};
    pp = b ? {s & m[XLEN-1], m} : '0;
`ifdef XC_MALU_MUL_ITER_CLMUL_EN
    sm = o[2] ? hi ^ pp : sub ? hi - pp : hi + pp;
`else
    sm = sub ? hi - pp : hi + pp;
`endif
    return {sm, a[XLEN-1:1]};
  endfunction
  assign bus.in_ready  = state == IDLE && !flush;
  assign bus.out_valid = state == DONE;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = cnt == CW'(N - 1);
  assign hi_sel        = op_r[2] ? op_r[0] : |op_r[1:0];
`ifdef XC_MALU_MUL_ITER_CLMUL_EN
  assign rsv = &op_r[2:1];
`else
  assign rsv = op_r[2];
`endif
  assign bus.result = rsv ? '0 : hi_sel ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  always_comb begin
    acc_n = acc;
    for (int j = 0; j < BPC; j++)
      acc_n = step(acc_n, rs1_r, op_r, rs2_r[j], op_r == 3'b001 && last && j == BPC - 1);
  end
  always_comb begin
    state_n = flush ? IDLE
            : state == IDLE ? (bus.in_valid ? BUSY : IDLE)
            : state == BUSY ? (last ? DONE : BUSY)
            : (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) begin
      cnt   <= '0;
      acc   <= '0;
      op_r  <= '0;
      rs1_r <= '0;
      rs2_r <= '0;
    end else if (accept) begin
      cnt   <= '0;
      acc   <= '0;
      op_r  <= bus.op;
      rs1_r <= bus.rs1;
      rs2_r <= bus.rs2;
    end else if (state == BUSY) begin
      cnt   <= cnt + 1'b1;
      acc   <= acc_n;
      rs2_r <= rs2_r >> BPC;
    end
endmodule

// File: tb/tb_xc_malu_mul_iter.sv
// tb_xc_malu_mul_iter: directed vector table plus handshake, flush and reset sequences
module tb_xc_malu_mul_iter;
  logic g_clk = 0, g_resetn = 0, flush1 = 0, flush4 = 0;
  int pass = 0, total = 0;
  always #5 g_clk = ~g_clk;
  xc_malu_mul_iter_if #(.XLEN(32)) b1();
  xc_malu_mul_iter_if #(.XLEN(32)) b4();
  xc_malu_mul_iter #(.XLEN(32), .BPC(1)) dut1 (.g_clk(g_clk), .g_resetn(g_resetn), .flush(flush1), .bus(b1));
  xc_malu_mul_iter #(.XLEN(32), .BPC(4)) dut4 (.g_clk(g_clk), .g_resetn(g_resetn), .flush(flush4), .bus(b4));
`ifdef XC_MALU_MUL_ITER_CLMUL_EN
  localparam logic [31:0] CL_LO = 32'h00000005, CL_HI = 32'h40000000;
`else
  localparam logic [31:0] CL_LO = 32'h0, CL_HI = 32'h0;
`endif
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;
  vec_t vecs[15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic run1(input int idx, input vec_t v);
    int n = 0;
    while (!b1.in_ready && n < 50) begin @(negedge g_clk); n++; end
    b1.op = v.op; b1.rs1 = v.a; b1.rs2 = v.b; b1.in_valid = 1;
    @(posedge g_clk); @(negedge g_clk);
    b1.in_valid = 0; b1.rs1 = ~v.a; b1.rs2 = ~v.b; b1.op = ~v.op;
    n = 0;
    while (!b1.out_valid && n < 40) begin @(posedge g_clk); n++; @(negedge g_clk); end
    chk($sformatf("vec%0d_latency", idx), n, 32);
    chk($sformatf("vec%0d_result", idx), b1.result, v.exp);
    b1.out_ready = 1;
    @(posedge g_clk); @(negedge g_clk);
    b1.out_ready = 0;
  endtask
  initial begin
    int n;
    logic seen;
    vecs[0]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[2]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[3]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[4]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[6]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780};
    vecs[7]  = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[8]  = '{3'b011, 32'h80000000, 32'h00000004, 32'h00000002};
    vecs[9]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[10] = '{3'b100, 32'h00000003, 32'h00000003, CL_LO};
    vecs[11] = '{3'b101, 32'h80000000, 32'h80000000, CL_HI};
    vecs[12] = '{3'b110, 32'h00000005, 32'h00000007, 32'h00000000};
    vecs[13] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[14] = '{3'b000, 32'h00000007, 32'h00000006, 32'h0000002A};
    b1.in_valid = 0; b1.out_ready = 0; b1.op = 0; b1.rs1 = 0; b1.rs2 = 0;
    b4.in_valid = 0; b4.out_ready = 0; b4.op = 0; b4.rs1 = 0; b4.rs2 = 0;
    repeat (2) @(negedge g_clk);
    chk("rst_in_ready1", {31'b0, b1.in_ready}, 1);
    chk("rst_out_valid1", {31'b0, b1.out_valid}, 0);
    chk("rst_result1", b1.result, 0);
    g_resetn = 1;
    @(negedge g_clk);
    chk("rst_in_ready4", {31'b0, b4.in_ready}, 1);
    chk("rst_out_valid4", {31'b0, b4.out_valid}, 0);
    chk("rst_result4", b4.result, 0);
    for (int i = 0; i < 15; i++) run1(i, vecs[i]);
    // BPC=4: 8 busy cycles, back-pressure, then no re-accept on the draining edge
    b4.op = 3'b000; b4.rs1 = 7; b4.rs2 = 6; b4.in_valid = 1;
    @(posedge g_clk); @(negedge g_clk);
    b4.in_valid = 0; b4.rs1 = 32'hDEADBEEF; b4.rs2 = 32'h12345678;
    n = 0;
    while (!b4.out_valid && n < 20) begin @(posedge g_clk); n++; @(negedge g_clk); end
    chk("bpc4_latency", n, 8);
    chk("bpc4_result", b4.result, 32'h2A);
    for (int k = 0; k < 5; k++) begin
      @(posedge g_clk); @(negedge g_clk);
      chk($sformatf("hold%0d_valid", k), {31'b0, b4.out_valid}, 1);
      chk($sformatf("hold%0d_result", k), b4.result, 32'h2A);
    end
    b4.in_valid = 1; b4.out_ready = 1;
    @(posedge g_clk); @(negedge g_clk);
    chk("drain_out_valid", {31'b0, b4.out_valid}, 0);
    chk("drain_in_ready", {31'b0, b4.in_ready}, 1);
    b4.in_valid = 0; b4.out_ready = 0;
    // flush: blocks in_ready, then aborts in busy cycle 10
    flush1 = 1;
    #1 chk("flush_idle_in_ready", {31'b0, b1.in_ready}, 0);
    @(negedge g_clk);
    flush1 = 0;
    b1.op = 3'b011; b1.rs1 = 32'hFFFFFFFF; b1.rs2 = 32'hFFFFFFFF; b1.in_valid = 1;
    @(posedge g_clk); @(negedge g_clk);
    b1.in_valid = 0;
    repeat (9) begin @(posedge g_clk); @(negedge g_clk); end
    flush1 = 1;
    @(posedge g_clk); @(negedge g_clk);
    flush1 = 0;
    #1 chk("flush_in_ready", {31'b0, b1.in_ready}, 1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin @(negedge g_clk); seen |= b1.out_valid; end
    chk("flush_no_out_valid", {31'b0, seen}, 0);
    // asynchronous reset in the middle of a busy operation
    b1.op = 3'b011; b1.rs1 = 32'hFFFFFFFF; b1.rs2 = 32'hFFFFFFFF; b1.in_valid = 1;
    @(posedge g_clk); @(negedge g_clk);
    b1.in_valid = 0;
    repeat (5) begin @(posedge g_clk); @(negedge g_clk); end
    chk("busy_in_ready", {31'b0, b1.in_ready}, 0);
    #2 g_resetn = 0;
    #1;
    chk("arst_in_ready", {31'b0, b1.in_ready}, 1);
    chk("arst_out_valid", {31'b0, b1.out_valid}, 0);
    chk("arst_result", b1.result, 0);
    @(negedge g_clk);
    g_resetn = 1;
    @(negedge g_clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
